// File: rtl/pattern_test_sequencer.sv
// Pattern test sequencer: steps the generator select through each enabled pattern,
// checks the looped-back stream per pattern and reports a fail map, error total and pass/done.
module pattern_test_sequencer #(
  parameter int DATA_W         = 32,
  parameter int SETTLE_CYCLES  = 4,
  parameter int CHECK_SAMPLES  = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        pattern_mask,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic [1:0]        pattern_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        fail_map,
  output logic [15:0]       err_total
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CHECK_LAST   = 16'(CHECK_SAMPLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above lo.
  function automatic logic [2:0] find_set(input logic [3:0] m, input logic [2:0] lo);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= lo && m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        sel_q, sel_d;
  logic [7:0]        settle_q, settle_d;
  logic [15:0]       sample_q, sample_d;
  logic [15:0]       timeout_q, timeout_d;
  logic              first_q, first_d;
  logic [3:0]        fail_q, fail_d;
  logic [15:0]       err_q, err_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [DATA_W-1:0] prev_q;
  logic              rx_err;
  logic [2:0]        nxt;

  // The first sample of the alternate/increment patterns only seeds prev_q.
  always_comb begin
    rx_err = 1'b0;
    unique case (idx_q)
      2'd0: rx_err = (rx_data != '0);
      2'd1: rx_err = (rx_data != '1);
      2'd2: rx_err = !first_q && (rx_data != ~prev_q);
      2'd3: rx_err = !first_q && (rx_data != prev_q + DATA_W'(1));
      default: rx_err = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    settle_d  = settle_q;
    sample_d  = sample_q;
    timeout_d = timeout_q;
    first_d   = first_q;
    fail_d    = fail_q;
    err_d     = err_q;
    done_d    = done_q;
    pass_d    = pass_q;
    nxt       = 3'b000;
    if (abort) begin
      state_d = S_IDLE;
      sel_d   = 2'd0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mask_d = pattern_mask;
            fail_d = 4'd0;
            err_d  = 16'd0;
            done_d = 1'b0;
            pass_d = 1'b0;
            nxt    = find_set(pattern_mask, 3'd0);
            if (nxt[2]) begin
              idx_d   = nxt[1:0];
              state_d = S_SELECT;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end
          end
        end
        S_SELECT: begin
          sel_d    = idx_q;
          settle_d = 8'd0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d   = S_CHECK;
            sample_d  = 16'd0;
            timeout_d = 16'd0;
            first_d   = 1'b1;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        S_CHECK: begin
          if (rx_valid) begin
            sample_d  = sample_q + 16'd1;
            timeout_d = 16'd0;
            first_d   = 1'b0;
            if (rx_err) begin
              err_d         = sat_inc16(err_q);
              fail_d[idx_q] = 1'b1;
            end
            if (sample_q == CHECK_LAST) state_d = S_NEXT;
          end else if (timeout_q == TIMEOUT_LAST) begin
            fail_d[idx_q] = 1'b1;
            state_d       = S_NEXT;
          end else begin
            timeout_d = timeout_q + 16'd1;
          end
        end
        S_NEXT: begin
          nxt = find_set(mask_q, {1'b0, idx_q} + 3'd1);
          if (nxt[2]) begin
            idx_d   = nxt[1:0];
            state_d = S_SELECT;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (fail_q == 4'd0);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= 4'd0;
      idx_q     <= 2'd0;
      sel_q     <= 2'd0;
      settle_q  <= 8'd0;
      sample_q  <= 16'd0;
      timeout_q <= 16'd0;
      first_q   <= 1'b0;
      fail_q    <= 4'd0;
      err_q     <= 16'd0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      settle_q  <= settle_d;
      sample_q  <= sample_d;
      timeout_q <= timeout_d;
      first_q   <= first_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Previous-sample register is pure data; first_q masks its contents after reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CHECK && rx_valid) prev_q <= rx_data;
  end

  assign pattern_sel = sel_q;
  assign busy        = (state_q == S_SELECT) || (state_q == S_SETTLE) ||
                       (state_q == S_CHECK)  || (state_q == S_NEXT);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_map    = fail_q;
  assign err_total   = err_q;

endmodule

// File: tb/tb_pattern_test_sequencer.sv
// Scoreboard bench for pattern_test_sequencer: expected run results and select
// changes are queued at stimulus time and popped by a monitor on DUT events.
module tb_pattern_test_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [3:0]  pattern_mask;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic [1:0]  pattern_sel;
  logic        busy, done, pass;
  logic [3:0]  fail_map;
  logic [15:0] err_total;

  always #5 clk = ~clk;

  pattern_test_sequencer #(
    .DATA_W(32), .SETTLE_CYCLES(4), .CHECK_SAMPLES(256), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_mask(pattern_mask), .rx_valid(rx_valid), .rx_data(rx_data),
    .pattern_sel(pattern_sel), .busy(busy), .done(done), .pass(pass),
    .fail_map(fail_map), .err_total(err_total)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        p;
    logic [3:0]  fm;
    logic [15:0] err;
    logic [1:0]  sel;
  } res_t;

  res_t       res_q[$];
  logic [1:0] sel_exp_q[$];
  res_t       mon_e;
  logic       done_prev = 1'b0;
  logic [1:0] sel_prev  = 2'd0;

  task automatic push_res(input logic p, input logic [3:0] fm, input logic [15:0] err,
                          input logic [1:0] sel);
    res_t e;
    e.p = p; e.fm = fm; e.err = err; e.sel = sel;
    res_q.push_back(e);
  endtask

  // Monitor: a rising done completes a run; every select change must match the plan.
  always @(negedge clk) begin
    if (!rst) begin
      if (done && !done_prev) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", 32'(res_q.size()), 32'd1);
        end else begin
          mon_e = res_q.pop_front();
          chk("run_pass",      32'(pass),        32'(mon_e.p));
          chk("run_fail_map",  32'(fail_map),    32'(mon_e.fm));
          chk("run_err_total", 32'(err_total),   32'(mon_e.err));
          chk("run_final_sel", 32'(pattern_sel), 32'(mon_e.sel));
        end
      end
      if (pattern_sel != sel_prev) begin
        if (sel_exp_q.size() == 0) chk("sel_unexpected", 32'(pattern_sel), 32'(sel_prev));
        else chk("sel_sequence", 32'(pattern_sel), 32'(sel_exp_q.pop_front()));
      end
    end
    done_prev = done;
    sel_prev  = pattern_sel;
  end

  // Loopback stimulus state
  logic [31:0] d1 = 32'd0, d2 = 32'd0, inc_cnt = 32'd0;
  logic        alt = 1'b0;
  int          cyc, k;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ideal 2-cycle loopback of the selected pattern
  // mode 1: all-ones with one FFFF_FFFE at sample 100
  // mode 2: increment from FFFF_FFFE; mode 3: same with a 5->7 skip
  // mode 4: rx_valid held low
  task automatic drive_rx(input int mode);
    logic [31:0] g;
    logic [31:0] v;
    if (mode == 0) begin
      case (pattern_sel)
        2'd0:    g = 32'h0000_0000;
        2'd1:    g = 32'hFFFF_FFFF;
        2'd2:    g = alt ? 32'h5555_5555 : 32'hAAAA_AAAA;
        default: g = inc_cnt;
      endcase
      alt      = ~alt;
      inc_cnt  = inc_cnt + 32'd1;
      rx_data  = d2;
      d2       = d1;
      d1       = g;
      rx_valid = 1'b1;
    end else if (mode == 4) begin
      rx_valid = 1'b0;
      rx_data  = 32'd0;
    end else begin
      rx_valid = (cyc >= 8);
      if (rx_valid) begin
        if (mode == 1) v = (k == 100) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
        else begin
          v = 32'hFFFF_FFFE + 32'(k);
          if (mode == 3 && k >= 8) v = v + 32'd1;
        end
        rx_data = v;
        k++;
      end else begin
        rx_data = 32'd0;
      end
    end
    cyc++;
  endtask

  task automatic start_run(input logic [3:0] m);
    pattern_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int mode, input int budget);
    int n;
    n = 0; cyc = 0; k = 0;
    while (!done && n < budget) begin
      drive_rx(mode);
      tick();
      n++;
    end
    rx_valid = 1'b0;
    chk("run_completed", 32'(done), 32'd1);
  endtask

  task automatic wait_sel(input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (pattern_sel != s && n < budget) begin
      drive_rx(0);
      tick();
      n++;
    end
    chk("reach_sel", 32'(pattern_sel), 32'(s));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sel"},  32'(pattern_sel), 32'd0);
    chk({tag, "_busy"}, 32'(busy),        32'd0);
    chk({tag, "_done"}, 32'(done),        32'd0);
    chk({tag, "_pass"}, 32'(pass),        32'd0);
    chk({tag, "_fail"}, 32'(fail_map),    32'd0);
    chk({tag, "_err"},  32'(err_total),   32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern_mask = 4'd0; rx_valid = 1'b0; rx_data = 32'd0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // All four patterns, clean loopback
    sel_exp_q.push_back(2'd1); sel_exp_q.push_back(2'd2); sel_exp_q.push_back(2'd3);
    push_res(1'b1, 4'b0000, 16'd0, 2'd3);
    start_run(4'b1111);
    chk("busy_after_start", 32'(busy), 32'd1);
    run(0, 3000);

    // Ones pattern with one corrupted word
    sel_exp_q.push_back(2'd1);
    push_res(1'b0, 4'b0010, 16'd1, 2'd1);
    start_run(4'b0010);
    run(1, 2000);

    // Increment across the 32-bit wrap, then with a skipped value
    sel_exp_q.push_back(2'd3);
    push_res(1'b1, 4'b0000, 16'd0, 2'd3);
    start_run(4'b1000);
    run(2, 2000);
    push_res(1'b0, 4'b1000, 16'd1, 2'd3);
    start_run(4'b1000);
    run(3, 2000);

    // Alternate pattern with no rx_valid: timeout
    sel_exp_q.push_back(2'd2);
    push_res(1'b0, 4'b0100, 16'd0, 2'd2);
    start_run(4'b0100);
    run(4, 3000);

    // Start while busy is ignored; abort in CHECK of pattern 2
    sel_exp_q.push_back(2'd0); sel_exp_q.push_back(2'd1);
    sel_exp_q.push_back(2'd2); sel_exp_q.push_back(2'd0);
    start_run(4'b1111);
    wait_sel(2'd1, 2000);
    repeat (10) begin drive_rx(0); tick(); end
    pattern_mask = 4'b0000;
    start = 1'b1;
    drive_rx(0);
    tick();
    start = 1'b0;
    chk("start_busy_ignored_busy", 32'(busy), 32'd1);
    chk("start_busy_ignored_done", 32'(done), 32'd0);
    wait_sel(2'd2, 2000);
    repeat (20) begin drive_rx(0); tick(); end
    abort = 1'b1;
    drive_rx(0);
    tick();
    abort = 1'b0;
    rx_valid = 1'b0;
    chk_idle_outputs("abort");
    tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Empty mask: straight to DONE with pass
    push_res(1'b1, 4'b0000, 16'd0, 2'd0);
    start_run(4'b0000);
    chk("mask0_done", 32'(done), 32'd1);
    chk("mask0_pass", 32'(pass), 32'd1);
    chk("mask0_busy", 32'(busy), 32'd0);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_outputs("rst_after_done");
    tick();

    chk("results_drained", 32'(res_q.size()), 32'd0);
    chk("sel_plan_drained", 32'(sel_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
